// File: rtl/id_ex_stage.sv
// Decode stage: 32x32 register file, immediate generation, ALU-control decode
// and the ID/EX pipeline register with stall, flush and bubble handling.
module id_ex_stage #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter bit          BYPASS     = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  id_valid,
   input  logic [31:0]           id_instr,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  wb_we,
   input  logic [4:0]            wb_rd,
   input  logic [DATA_WIDTH-1:0] wb_data,
   output logic                  ex_valid,
   output logic [DATA_WIDTH-1:0] ex_a,
   output logic [DATA_WIDTH-1:0] ex_b,
   output logic [2:0]            ex_alu_control,
   output logic [DATA_WIDTH-1:0] ex_rs2_data,
   output logic [DATA_WIDTH-1:0] ex_imm,
   output logic [4:0]            ex_rd,
   output logic                  ex_reg_write,
   output logic                  ex_mem_read,
   output logic                  ex_mem_write,
   output logic                  ex_branch,
   output logic                  ex_illegal
);

   localparam int unsigned REG_CNT = 32;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_SUB    = 7'b0100000;
   localparam logic [2:0] F3_WORD   = 3'b010;
   localparam logic [2:0] F3_BEQ    = 3'b000;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   typedef struct packed {
      logic                  valid;
      logic [DATA_WIDTH-1:0] a;
      logic [DATA_WIDTH-1:0] b;
      logic [2:0]            alu;
      logic [DATA_WIDTH-1:0] rs2_data;
      logic [DATA_WIDTH-1:0] imm;
      logic [4:0]            rd;
      logic                  reg_write;
      logic                  mem_read;
      logic                  mem_write;
      logic                  branch;
      logic                  illegal;
   } ex_t;

   logic [DATA_WIDTH-1:0] rf [REG_CNT];
   logic [DATA_WIDTH-1:0] rs1_val, rs2_val;
   logic [DATA_WIDTH-1:0] imm_i, imm_s, imm_b;
   logic [4:0]            rs1, rs2, rd;
   logic [6:0]            opcode, funct7;
   logic [2:0]            funct3;
   logic [3:0]            alu_sel;
   logic                  legal;
   ex_t                   dec, ex_q;

   // Shared funct3 -> {supported, alu code} map for R-type and I-type ALU ops
   function automatic logic [3:0] f3_alu(input logic [2:0] f3);
      case (f3)
         3'b000:  return {1'b1, ALU_ADD};
         3'b111:  return {1'b1, ALU_AND};
         3'b110:  return {1'b1, ALU_OR};
         3'b010:  return {1'b1, ALU_SLT};
         default: return 4'b0000;
      endcase
   endfunction

   assign opcode = id_instr[6:0];
   assign rd     = id_instr[11:7];
   assign funct3 = id_instr[14:12];
   assign rs1    = id_instr[19:15];
   assign rs2    = id_instr[24:20];
   assign funct7 = id_instr[31:25];

   assign imm_i = {{(DATA_WIDTH-12){id_instr[31]}}, id_instr[31:20]};
   assign imm_s = {{(DATA_WIDTH-12){id_instr[31]}}, id_instr[31:25], id_instr[11:7]};
   assign imm_b = {{(DATA_WIDTH-13){id_instr[31]}}, id_instr[31], id_instr[7],
                   id_instr[30:25], id_instr[11:8], 1'b0};

   // Register-file reads; x0 is hard zero, optional same-cycle write-back forwarding
   always_comb begin
      rs1_val = '0;
      rs2_val = '0;
      if (rs1 != 5'd0) begin
         if (BYPASS && wb_we && (wb_rd == rs1)) rs1_val = wb_data;
         else                                   rs1_val = rf[rs1];
      end
      if (rs2 != 5'd0) begin
         if (BYPASS && wb_we && (wb_rd == rs2)) rs2_val = wb_data;
         else                                   rs2_val = rf[rs2];
      end
   end

   always_comb begin
      dec     = '0;
      legal   = 1'b0;
      alu_sel = f3_alu(funct3);
      dec.a   = rs1_val;
      case (opcode)
         OP_R: begin
            dec.b         = rs2_val;
            dec.rd        = rd;
            dec.reg_write = 1'b1;
            if (funct7 == F7_BASE) begin
               legal   = alu_sel[3];
               dec.alu = alu_sel[2:0];
            end else if ((funct7 == F7_SUB) && (funct3 == 3'b000)) begin
               legal   = 1'b1;
               dec.alu = ALU_SUB;
            end
         end
         OP_IMM: begin
            dec.b         = imm_i;
            dec.imm       = imm_i;
            dec.rd        = rd;
            dec.reg_write = 1'b1;
            legal         = alu_sel[3];
            dec.alu       = alu_sel[2:0];
         end
         OP_LOAD: begin
            dec.b         = imm_i;
            dec.imm       = imm_i;
            dec.rd        = rd;
            dec.reg_write = 1'b1;
            dec.mem_read  = 1'b1;
            dec.alu       = ALU_ADD;
            legal         = (funct3 == F3_WORD);
         end
         OP_STORE: begin
            dec.b         = imm_s;
            dec.imm       = imm_s;
            dec.mem_write = 1'b1;
            dec.rs2_data  = rs2_val;
            dec.alu       = ALU_ADD;
            legal         = (funct3 == F3_WORD);
         end
         OP_BRANCH: begin
            dec.b      = rs2_val;
            dec.imm    = imm_b;
            dec.branch = 1'b1;
            dec.alu    = ALU_SUB;
            legal      = (funct3 == F3_BEQ);
         end
         default: legal = 1'b0;
      endcase
      // Unsupported encodings become a bubble that only carries the illegal flag
      if (legal) begin
         dec.valid = 1'b1;
      end else begin
         dec         = '0;
         dec.illegal = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < REG_CNT; i++) rf[i] <= '0;
      end else if (wb_we && (wb_rd != 5'd0)) begin
         rf[wb_rd] <= wb_data;
      end
   end

   // ID/EX register: flush beats stall beats load
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        ex_q <= '0;
      else if (flush)    ex_q <= '0;
      else if (!stall)   ex_q <= id_valid ? dec : '0;
   end

   assign ex_valid       = ex_q.valid;
   assign ex_a           = ex_q.a;
   assign ex_b           = ex_q.b;
   assign ex_alu_control = ex_q.alu;
   assign ex_rs2_data    = ex_q.rs2_data;
   assign ex_imm         = ex_q.imm;
   assign ex_rd          = ex_q.rd;
   assign ex_reg_write   = ex_q.reg_write;
   assign ex_mem_read    = ex_q.mem_read;
   assign ex_mem_write   = ex_q.mem_write;
   assign ex_branch      = ex_q.branch;
   assign ex_illegal     = ex_q.illegal;

endmodule
